tick_sample_fifo: RTL

Periodic sample-capture buffer downstream of the programmable time base. Each time-base tick (one-cycle interrupt-enable pulse) latches the current ADC word into an on-chip FIFO. The FIFO raises a level-triggered interrupt to the host controller when its fill reaches a threshold, and the host drains it through a read strobe. Overrun is flagged sticky.

---
 rtl/tick_sample_fifo.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/tick_sample_fifo.sv
// tick_sample_fifo: periodic ADC sample-capture buffer.
// Each time-base tick (gated by enable) writes the current ADC word into a
// 2**DEPTH_LOG2-entry FIFO. The host reads it back with rd_en, one cycle of
// read latency. A three-state FSM raises a level-triggered irq at a fill
// threshold. Ticks that arrive while the FIFO is full set a sticky overrun flag.
// Optional build macro: CAPTURE_TIMESTAMP_EN. When it is defined, each entry
// also carries a 16-bit tick count, placed in the MSBs of rd_data.
module tick_sample_fifo #(
   parameter int DATA_W     = 14,
   parameter int DEPTH_LOG2 = 4,
   parameter int IRQ_THRESH = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  tick,
   input  logic                  enable,
   input  logic [DATA_W-1:0]     adc_data,
   input  logic                  rd_en,
`ifdef CAPTURE_TIMESTAMP_EN
   output logic [DATA_W+15:0]    rd_data,
`else
   output logic [DATA_W-1:0]     rd_data,
`endif
   output logic                  rd_valid,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  irq,
   input  logic                  irq_ack,
   output logic                  overrun,
   input  logic                  overrun_clr
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef CAPTURE_TIMESTAMP_EN
   localparam int ENTRY_W = DATA_W + 16;
`else
   localparam int ENTRY_W = DATA_W;
`endif
   localparam logic [DEPTH_LOG2:0] LEVEL_FULL   = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] LEVEL_THRESH = (DEPTH_LOG2+1)'(IRQ_THRESH);

   typedef enum logic [1:0] {
      IRQ_WAIT  = 2'd0,
      IRQ_PEND  = 2'd1,
      IRQ_ACKED = 2'd2
   } irq_state_t;

   // Storage array with no reset, so that it can map onto block RAM.
   logic [ENTRY_W-1:0]     mem [DEPTH];

   logic [DEPTH_LOG2-1:0]  wr_ptr_reg;
   logic [DEPTH_LOG2-1:0]  rd_ptr_reg;
   logic [DEPTH_LOG2:0]    level_reg;
   logic [DEPTH_LOG2:0]    level_next;
   logic [ENTRY_W-1:0]     rd_data_reg;
   logic                   rd_valid_reg;
   logic                   overrun_reg;
   irq_state_t             irq_state_reg;
   irq_state_t             irq_state_next;
   logic                   irq_next;

   logic                   capture;
   logic                   full;
   logic                   empty;
   logic                   wr_do;
   logic                   rd_do;
   logic                   drop;
   logic [ENTRY_W-1:0]     entry_in;

   assign capture = tick & enable;
   assign full    = (level_reg == LEVEL_FULL);
   assign empty   = (level_reg == '0);
   // A full FIFO still accepts a tick when the host frees a slot in the same cycle.
   assign wr_do   = capture & (~full | rd_en);
   // A read only happens when there is data. A write into an empty FIFO
   // during the same cycle is not visible to that read.
   assign rd_do   = rd_en & ~empty;
   assign drop    = capture & full & ~rd_en;

`ifdef CAPTURE_TIMESTAMP_EN
   logic [15:0] ts_reg;

   // Tick counter. It counts every enabled tick, whether the sample is kept
   // or dropped, and it wraps naturally.
   always_ff @(posedge clock) begin
      if (reset)
         ts_reg <= '0;
      else if (capture)
         ts_reg <= ts_reg + 16'd1;
   end

   assign entry_in = {ts_reg, adc_data};
`else
   assign entry_in = adc_data;
`endif

   // Write port of the storage array.
   always_ff @(posedge clock) begin
      if (wr_do && !reset)
         mem[wr_ptr_reg] <= entry_in;
   end

   // Registered read port. Reading a full FIFO while it is being written
   // returns the old (oldest) entry, because the read takes the value before the write.
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_data_reg  <= '0;
         rd_valid_reg <= 1'b0;
      end else begin
         rd_valid_reg <= rd_do;
         if (rd_do)
            rd_data_reg <= mem[rd_ptr_reg];
      end
   end

   // Next fill level: +1 on write only, -1 on read only, unchanged on both.
   always_comb begin
      level_next = level_reg;
      case ({wr_do, rd_do})
         2'b10:   level_next = level_reg + 1'b1;
         2'b01:   level_next = level_reg - 1'b1;
         default: level_next = level_reg;
      endcase
   end

   // Pointer and level registers. The pointers wrap naturally at the depth.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (wr_do)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (rd_do)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         level_reg <= level_next;
      end
   end

   // Sticky overrun flag. A new drop wins over a clear in the same cycle.
   always_ff @(posedge clock) begin
      if (reset)
         overrun_reg <= 1'b0;
      else if (drop)
         overrun_reg <= 1'b1;
      else if (overrun_clr)
         overrun_reg <= 1'b0;
   end

   // IRQ FSM state register.
   always_ff @(posedge clock) begin
      if (reset)
         irq_state_reg <= IRQ_WAIT;
      else
         irq_state_reg <= irq_state_next;
   end

   // IRQ FSM next state and output. irq is high only while pending.
   // The FSM must fall below the threshold again before it can re-arm.
   always_comb begin
      irq_state_next = irq_state_reg;
      irq_next       = 1'b0;
      case (irq_state_reg)
         IRQ_WAIT: begin
            if (level_reg >= LEVEL_THRESH)
               irq_state_next = IRQ_PEND;
         end
         IRQ_PEND: begin
            irq_next = 1'b1;
            if (irq_ack)
               irq_state_next = IRQ_ACKED;
         end
         IRQ_ACKED: begin
            if (level_reg < LEVEL_THRESH)
               irq_state_next = IRQ_WAIT;
         end
         default: irq_state_next = IRQ_WAIT;
      endcase
   end

   assign rd_data  = rd_data_reg;
   assign rd_valid = rd_valid_reg;
   assign level    = level_reg;
   assign irq      = irq_next;
   assign overrun  = overrun_reg;

endmodule
